// File: rtl/i2c_pkg.sv
// i2c_pkg: shared types and timing constants for the I2C memory loopback.
//   - master / slave state enums and the quarter-phase enum
//   - default clock rates and the derived bit / quarter lengths (clk cycles)
//   - quarter_cycles(): quarter length for any SYS_FREQ / I2C_FREQ pair
package i2c_pkg;

  localparam int SYS_FREQ_DEF = 40_000_000;
  localparam int I2C_FREQ_DEF = 100_000;
  localparam int BIT          = SYS_FREQ_DEF / I2C_FREQ_DEF;
  localparam int Q            = BIT / 4;
  localparam int MEM_DEPTH    = 128;

  typedef enum logic [3:0] {
    M_IDLE, M_WAIT, M_START, M_ADDR, M_ACK1, M_DATA, M_RDATA, M_ACK2, M_STOP
  } mst_state_e;

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_ACK1, S_WR, S_ACK2, S_RD
  } slv_state_e;

  typedef enum logic [1:0] {PH_Q0, PH_Q1, PH_Q2, PH_Q3} phase_e;

  function automatic int quarter_cycles(input int sys_freq, input int i2c_freq);
    return (sys_freq / i2c_freq) / 4;
  endfunction

endpackage

// File: rtl/i2c_master.sv
// i2c_master: turns one host request into a full I2C frame
// (START, address byte, ACK, data byte, ACK/NACK, STOP) and pulses done.
//   clk, rst      : system clock, asynchronous active-low reset
//   newd, wr      : request strobe (accepted only when idle), 1 = write
//   addr, wdata   : memory location and write data
//   sda_in        : resolved SDA bus level
//   sda_low       : 1 = pull SDA low, 0 = release
//   scl_low       : 1 = pull SCL low, 0 = release
//   done, rdata   : one-cycle completion pulse, read data (held until next read)
// sclk_ref is a free-running bit-phase reference, low in q0-q1, high in q2-q3.
module i2c_master
  import i2c_pkg::*;
#(
  parameter int SYS_FREQ = SYS_FREQ_DEF,
  parameter int I2C_FREQ = I2C_FREQ_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       newd,
  input  logic       wr,
  input  logic [6:0] addr,
  input  logic [7:0] wdata,
  input  logic       sda_in,
  output logic       sda_low,
  output logic       scl_low,
  output logic       done,
  output logic [7:0] rdata
);

  localparam int QC = quarter_cycles(SYS_FREQ, I2C_FREQ);
  localparam int CW = (QC > 1) ? $clog2(QC) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(QC - 1);

  mst_state_e    state_reg;
  phase_e        phase_reg;
  logic [CW-1:0] cnt_reg;
  logic [7:0]    tx_reg, rx_reg, wdata_reg;
  logic [2:0]    bit_reg;
  logic          wr_reg, ack_ok_reg, sclk_ref;
  logic          quarter_end, bit_end, sample_now;
  logic          dec_scl_low, dec_sda_low;

  assign quarter_end = (cnt_reg == CNT_LAST);
  assign bit_end     = quarter_end && (phase_reg == PH_Q3);
  // Bus outputs lag the phase counter by one cycle, as does sclk_ref; sample
  // one cycle into q2 so SCL has actually risen.
  assign sample_now  = sclk_ref && (phase_reg == PH_Q2) && (cnt_reg == CW'(1));

  // Bus levels wanted for the current element and quarter.
  always_comb begin
    dec_scl_low = 1'b0;
    dec_sda_low = 1'b0;
    case (state_reg)
      M_START: dec_sda_low = phase_reg inside {PH_Q2, PH_Q3};
      M_ADDR, M_DATA: begin
        dec_scl_low = phase_reg inside {PH_Q0, PH_Q1};
        dec_sda_low = ~tx_reg[7];
      end
      M_ACK1, M_RDATA, M_ACK2: dec_scl_low = phase_reg inside {PH_Q0, PH_Q1};
      M_STOP: begin
        dec_scl_low = phase_reg inside {PH_Q0, PH_Q1};
        dec_sda_low = phase_reg inside {PH_Q0, PH_Q1};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg  <= M_IDLE;
      phase_reg  <= PH_Q0;
      cnt_reg    <= '0;
      tx_reg     <= '0;
      rx_reg     <= '0;
      wdata_reg  <= '0;
      bit_reg    <= '0;
      wr_reg     <= 1'b0;
      ack_ok_reg <= 1'b0;
      sclk_ref   <= 1'b0;
      sda_low    <= 1'b0;
      scl_low    <= 1'b0;
      done       <= 1'b0;
      rdata      <= '0;
    end else begin
      done     <= 1'b0;
      sclk_ref <= phase_reg inside {PH_Q2, PH_Q3};
      scl_low  <= dec_scl_low;
      // SDA follows one cycle after SCL so it never moves on an SCL edge;
      // that also keeps START/STOP edges strictly inside SCL-high time.
      if (cnt_reg != '0) sda_low <= dec_sda_low;

      cnt_reg <= quarter_end ? '0 : cnt_reg + CW'(1);
      if (quarter_end) phase_reg <= phase_e'(phase_reg + 2'd1);

      case (state_reg)
        M_IDLE: if (newd) begin
          wr_reg    <= wr;
          wdata_reg <= wdata;
          tx_reg    <= {addr, ~wr};
          state_reg <= M_WAIT;
        end
        // Hold until the next q0 so every element is a whole bit period.
        M_WAIT: if (bit_end) state_reg <= M_START;
        M_START: if (bit_end) begin
          bit_reg   <= '0;
          state_reg <= M_ADDR;
        end
        M_ADDR, M_DATA: if (bit_end) begin
          tx_reg  <= {tx_reg[6:0], 1'b0};
          bit_reg <= bit_reg + 3'd1;
          if (bit_reg == 3'd7) state_reg <= (state_reg == M_ADDR) ? M_ACK1 : M_ACK2;
        end
        M_ACK1: begin
          if (sample_now) ack_ok_reg <= ~sda_in;
          if (bit_end) begin
            bit_reg <= '0;
            if (!ack_ok_reg) state_reg <= M_STOP;
            else if (wr_reg) begin
              tx_reg    <= wdata_reg;
              state_reg <= M_DATA;
            end else state_reg <= M_RDATA;
          end
        end
        M_RDATA: begin
          if (sample_now) rx_reg <= {rx_reg[6:0], sda_in};
          if (bit_end) begin
            bit_reg <= bit_reg + 3'd1;
            if (bit_reg == 3'd7) state_reg <= M_ACK2;
          end
        end
        M_ACK2: if (bit_end) state_reg <= M_STOP;
        M_STOP: if (bit_end) begin
          state_reg <= M_IDLE;
          done      <= 1'b1;
          if (!wr_reg && ack_ok_reg) rdata <= rx_reg;
        end
        default: state_reg <= M_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/i2c_mem_slave.sv
// i2c_mem_slave: 128-byte I2C memory target, edge-driven from the bus.
//   clk, rst : system clock, asynchronous active-low reset
//   sda_in   : resolved SDA level
//   scl_in   : resolved SCL level
//   sda_low  : 1 = pull SDA low (ACK / read data 0), 0 = release
// Reset loads location i with value i.
module i2c_mem_slave
  import i2c_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic sda_in,
  input  logic scl_in,
  output logic sda_low
);

  logic [7:0] mem [MEM_DEPTH];
  slv_state_e state_reg;
  logic       sda_prev, scl_prev, rw_reg;
  logic [7:0] sh_reg;
  logic [6:0] addr_reg;
  logic [3:0] cnt_reg;
  logic       start_det, stop_det, scl_rise, scl_fall;

  // START/STOP need SCL high on both samples so an SDA move that coincides
  // with an SCL edge is never mistaken for a bus condition.
  assign start_det = scl_in && scl_prev && sda_prev && !sda_in;
  assign stop_det  = scl_in && scl_prev && !sda_prev && sda_in;
  assign scl_rise  = scl_in && !scl_prev;
  assign scl_fall  = !scl_in && scl_prev;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < MEM_DEPTH; i++) mem[i] <= 8'(i);
      state_reg <= S_IDLE;
      sda_prev  <= 1'b1;
      scl_prev  <= 1'b1;
      rw_reg    <= 1'b0;
      sh_reg    <= '0;
      addr_reg  <= '0;
      cnt_reg   <= '0;
      sda_low   <= 1'b0;
    end else begin
      sda_prev <= sda_in;
      scl_prev <= scl_in;
      if (start_det) begin
        state_reg <= S_ADDR;
        cnt_reg   <= '0;
        sda_low   <= 1'b0;
      end else if (stop_det) begin
        state_reg <= S_IDLE;
        sda_low   <= 1'b0;
      end else begin
        case (state_reg)
          S_ADDR, S_WR: begin
            if (scl_rise) begin
              sh_reg  <= {sh_reg[6:0], sda_in};
              cnt_reg <= cnt_reg + 4'd1;
            end else if (scl_fall && cnt_reg == 4'd8) begin
              sda_low <= 1'b1;
              if (state_reg == S_ADDR) begin
                addr_reg  <= sh_reg[7:1];
                rw_reg    <= sh_reg[0];
                state_reg <= S_ACK1;
              end else begin
                mem[addr_reg] <= sh_reg;
                state_reg     <= S_ACK2;
              end
            end
          end
          S_ACK1: if (scl_fall) begin
            if (rw_reg) begin
              sda_low   <= ~mem[addr_reg][7];
              sh_reg    <= {mem[addr_reg][6:0], 1'b0};
              cnt_reg   <= 4'd1;
              state_reg <= S_RD;
            end else begin
              sda_low   <= 1'b0;
              cnt_reg   <= '0;
              state_reg <= S_WR;
            end
          end
          S_ACK2: if (scl_fall) begin
            sda_low   <= 1'b0;
            state_reg <= S_IDLE;
          end
          // cnt_reg counts bits already put on the bus; after the eighth,
          // release so the master can NACK.
          S_RD: if (scl_fall) begin
            if (cnt_reg == 4'd8) begin
              sda_low   <= 1'b0;
              state_reg <= S_IDLE;
            end else begin
              sda_low <= ~sh_reg[7];
              sh_reg  <= {sh_reg[6:0], 1'b0};
              cnt_reg <= cnt_reg + 4'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: rtl/i2c_mem_top.sv
// i2c_mem_top: I2C master (e1) and 128-byte memory slave (e2) on an
// internal pulled-up open-drain bus.
//   clk, rst     : system clock, asynchronous active-low reset
//   newd, wr     : request strobe, 1 = write / 0 = read
//   addr, wdata  : memory location (0-127), write data
//   rdata, done  : read data, one-cycle completion pulse
module i2c_mem_top
  import i2c_pkg::*;
#(
  parameter int SYS_FREQ = SYS_FREQ_DEF,
  parameter int I2C_FREQ = I2C_FREQ_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       newd,
  input  logic       wr,
  input  logic [7:0] wdata,
  input  logic [6:0] addr,
  output logic [7:0] rdata,
  output logic       done
);

  tri1  sda, scl;
  logic m_sda_low, m_scl_low, s_sda_low;

  assign sda = m_sda_low ? 1'b0 : 1'bz;
  assign sda = s_sda_low ? 1'b0 : 1'bz;
  assign scl = m_scl_low ? 1'b0 : 1'bz;

  i2c_master #(
    .SYS_FREQ(SYS_FREQ),
    .I2C_FREQ(I2C_FREQ)
  ) e1 (
    .clk    (clk),
    .rst    (rst),
    .newd   (newd),
    .wr     (wr),
    .addr   (addr),
    .wdata  (wdata),
    .sda_in (sda),
    .sda_low(m_sda_low),
    .scl_low(m_scl_low),
    .done   (done),
    .rdata  (rdata)
  );

  i2c_mem_slave e2 (
    .clk    (clk),
    .rst    (rst),
    .sda_in (sda),
    .scl_in (scl),
    .sda_low(s_sda_low)
  );

endmodule

// File: tb/tb_i2c_mem_top.sv
// tb_i2c_mem_top: randomized frames checked against an array model of the
// memory, plus bus-protocol and sclk_ref monitors.
module tb_i2c_mem_top;

  localparam int SYS_FREQ = 4_000_000;
  localparam int I2C_FREQ = 100_000;
  localparam int BIT      = SYS_FREQ / I2C_FREQ;
  localparam int LAT_MIN  = 20 * BIT;
  localparam int LAT_MAX  = 21 * BIT + 2;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       newd = 1'b0;
  logic       wr = 1'b0;
  logic [7:0] wdata = '0;
  logic [6:0] addr = '0;
  logic [7:0] rdata;
  logic       done;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] ref_mem [128];
  logic [7:0] ref_rdata;

  int   n_start = 0, n_stop = 0, n_illegal = 0;
  int   sclk_rises = 0, sclk_bad = 0, cyc = 0, last_rise = -1;
  logic sda_q = 1'b1, scl_q = 1'b1, sref_q = 1'b0;

  i2c_mem_top #(
    .SYS_FREQ(SYS_FREQ),
    .I2C_FREQ(I2C_FREQ)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .newd (newd),
    .wr   (wr),
    .wdata(wdata),
    .addr (addr),
    .rdata(rdata),
    .done (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  // Bus monitor: START/STOP are SDA edges with SCL high on both samples;
  // SDA moving on the same sample SCL rises is a protocol violation.
  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      last_rise = -1;
      sda_q     = 1'b1;
      scl_q     = 1'b1;
      sref_q    = 1'b0;
    end else begin
      if (scl_q && dut.scl && sda_q && !dut.sda) n_start++;
      if (scl_q && dut.scl && !sda_q && dut.sda) n_stop++;
      if (!scl_q && dut.scl && (dut.sda !== sda_q)) n_illegal++;
      if (dut.e1.sclk_ref && !sref_q) begin
        if (last_rise >= 0 && (cyc - last_rise) != BIT) sclk_bad++;
        sclk_rises++;
        last_rise = cyc;
      end
      sda_q  = dut.sda;
      scl_q  = dut.scl;
      sref_q = dut.e1.sclk_ref;
    end
  end

  task automatic model_reset();
    for (int i = 0; i < 128; i++) ref_mem[i] = 8'(i);
    ref_rdata = 8'h00;
  endtask

  task automatic frame(input bit is_wr, input logic [6:0] a, input logic [7:0] d, input string tag);
    int cycles;
    int s0, p0;
    s0 = n_start;
    p0 = n_stop;
    @(posedge clk); #1;
    newd = 1'b1; wr = is_wr; addr = a; wdata = d;
    @(posedge clk); #1;
    newd = 1'b0; wr = 1'($urandom); addr = 7'($urandom); wdata = 8'($urandom);
    cycles = 0;
    while (!done && cycles < LAT_MAX + 10) begin
      @(negedge clk);
      cycles++;
    end
    if (is_wr) ref_mem[a] = d;
    else ref_rdata = ref_mem[a];
    $display("frame %s: %s addr=0x%02h wdata=0x%02h rdata=0x%02h exp=0x%02h cycles=%0d",
             tag, is_wr ? "WR" : "RD", a, d, rdata, ref_rdata, cycles);
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_latency_in_range"}, 32'(cycles >= LAT_MIN && cycles <= LAT_MAX), 32'd1);
    check({tag, "_rdata"}, 32'(rdata), 32'(ref_rdata));
    check({tag, "_start_cnt"}, 32'(n_start - s0), 32'd1);
    check({tag, "_stop_cnt"}, 32'(n_stop - p0), 32'd1);
    @(negedge clk);
    check({tag, "_done_one_cycle"}, 32'(done), 32'd0);
  endtask

  initial begin
    #(2_000_000);
    $display("FAIL watchdog: simulation did not finish, limit 2000000 time units");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int dones;
    logic [6:0] a, ra;
    logic [7:0] d;

    model_reset();
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("reset_done", 32'(done), 32'd0);
    check("reset_rdata", 32'(rdata), 32'd0);
    check("reset_sda_idle", 32'(dut.sda), 32'd1);
    check("reset_scl_idle", 32'(dut.scl), 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (3 * BIT) @(posedge clk);

    frame(1'b0, 7'd5, 8'h00, "rd_reset_pattern");
    frame(1'b1, 7'h12, 8'hA5, "wr_12");
    frame(1'b0, 7'h12, 8'h00, "rd_12");
    frame(1'b1, 7'd127, 8'hFF, "wr_127");
    frame(1'b1, 7'd0, 8'h00, "wr_0");
    frame(1'b0, 7'd127, 8'h00, "rd_127");
    frame(1'b0, 7'd0, 8'h00, "rd_0");
    frame(1'b0, 7'd1, 8'h00, "rd_1");

    // Second request while busy must be dropped.
    @(posedge clk); #1;
    newd = 1'b1; wr = 1'b1; addr = 7'h20; wdata = 8'h3C;
    @(posedge clk); #1;
    newd = 1'b0;
    dones = 0;
    for (int i = 0; i < 44 * BIT; i++) begin
      @(negedge clk);
      if (done) dones++;
      if (i == 5 * BIT) begin
        newd = 1'b1; wr = 1'b1; addr = 7'h21; wdata = 8'hEE;
      end else if (i == 5 * BIT + 1) begin
        newd = 1'b0;
      end
    end
    $display("busy: done pulses=%0d", dones);
    check("busy_done_count", 32'(dones), 32'd1);
    ref_mem[7'h20] = 8'h3C;
    frame(1'b0, 7'h21, 8'h00, "rd_21_after_busy");
    frame(1'b0, 7'h20, 8'h00, "rd_20_after_busy");

    // Reset in the middle of a write.
    @(posedge clk); #1;
    newd = 1'b1; wr = 1'b1; addr = 7'd3; wdata = 8'h77;
    @(posedge clk); #1;
    newd = 1'b0;
    repeat (14 * BIT) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    $display("reset mid-write: sda=%0b scl=%0b done=%0b rdata=0x%02h", dut.sda, dut.scl, done, rdata);
    check("midrst_sda", 32'(dut.sda), 32'd1);
    check("midrst_scl", 32'(dut.scl), 32'd1);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_rdata", 32'(rdata), 32'd0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    model_reset();
    frame(1'b0, 7'd3, 8'h00, "rd_3_after_rst");

    for (int k = 0; k < 20; k++) begin
      a  = 7'($urandom_range(0, 127));
      d  = 8'($urandom);
      ra = ($urandom_range(0, 1) == 1) ? a : 7'($urandom_range(0, 127));
      frame(1'b1, a, d, $sformatf("rnd%0d_wr", k));
      frame(1'b0, ra, 8'h00, $sformatf("rnd%0d_rd", k));
    end

    check("sda_change_while_scl_high", 32'(n_illegal), 32'd0);
    check("sclk_ref_period_errors", 32'(sclk_bad), 32'd0);
    check("sclk_ref_running", 32'(sclk_rises > 100), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/i2c_mem_top.md
# i2c_mem_top

Self-contained I2C loopback subsystem: an I2C master (instance `e1`) and a 128-byte I2C memory slave (instance `e2`) joined by an internal open-drain SDA/SCL bus. A host-side parallel request (`newd`, `wr`, `addr`, `wdata`) becomes one complete I2C frame. Completion is reported on `done`, with read data on `rdata`. This block is the DUT for the I2C memory verification environment; the `i2c_if` interface bundles its ports plus `sclk_ref`.

## Interface
- `SYS_FREQ`, default 40_000_000: system clock frequency, Hz.
- `I2C_FREQ`, default 100_000: SCL bit rate, Hz. Bit period `BIT = SYS_FREQ/I2C_FREQ` clk cycles (400); `Q = BIT/4` (100).
- `clk` in 1: system clock, all logic on rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `newd` in 1: request strobe, sampled only while the master is idle.
- `wr` in 1: 1 = write, 0 = read.
- `wdata` in 8: write data.
- `addr` in 7: memory location, 0–127.
- `rdata` out 8: read data, valid when `done` = 1; held until the next read completes.
- `done` out 1: one-cycle pulse at frame end.
- `e1.sclk_ref` internal 1: master bit-phase reference, hierarchically observable by the bench.

## Operation
- Bus:
  - Internal `sda`/`scl` are pulled up (`tri1`).
  - Each side drives only 0 or Z.
  - Idle is both high.
- Reset values:
  - `done` = 0, `rdata` = 0.
  - Master idle, bus released.
  - Memory location `i` = `i`.
- Master state machine: IDLE → START → ADDR(8 bits) → ACK1 → DATA(8 bits, write) or RDATA(8 bits, read) → ACK2 → STOP → IDLE.
  - In IDLE with `newd` = 1: capture `addr`, `wr`, `wdata`, then enter START.
  - `newd` while busy is ignored.
  - ADDR byte = `{addr, ~wr}`, MSB first; bus R/W bit 0 = write.
  - ACK1/ACK2 on a write: master releases SDA and samples it.
  - NACK at ACK1 (should not occur): skip the data phase, go straight to STOP, still pulse `done`. For a read, `rdata` is left unchanged.
  - Read, RDATA phase: slave drives `mem[addr]` MSB first; master samples each bit at SCL high.
  - Read, ACK2: master drives NACK (SDA released high).
- Slave:
  - Detects START as SDA falling while SCL is high; detects STOP as SDA rising while SCL is high.
  - Shifts in the address byte and always ACKs it.
  - On write, shifts in data, ACKs, and on the ACK bit writes `mem[addr]` = data.
  - On read, shifts out `mem[addr]`.
  - A START or STOP in mid-frame resets the slave to its wait-for-START state.
- Completion: after STOP, the master returns to IDLE and pulses `done` for 1 cycle. On a read, `rdata` updates in that same cycle.

## Timing
- Every frame element lasts one `BIT`, split into quarters q0–q3 of `Q` cycles each.
- SCL per data/ACK bit: low in q0–q1, high in q2–q3.
- SDA is changed only in q0 and sampled at the q2 start.
- START: SDA falls at q2 while SCL is high.
- STOP: SDA rises at q2 while SCL is high.
- `sclk_ref`:
  - Free-running whenever out of reset, including when idle.
  - Low in q0–q1, high in q2–q3.
  - Its quarter counter is reset only by `rst`.
- Frame length:
  - Write: START + 8 + ACK + 8 + ACK + STOP = 20 `BIT`.
  - Read: same count, 20 `BIT`.
- Latency: `done` rises within 20·`BIT` + 2 clk cycles after `newd` is sampled, plus up to one `BIT` of alignment to the next q0.
- The next `newd` may be sampled in the cycle after `done`.
- `rst` asserted mid-frame:
  - Immediately releases SDA/SCL.
  - Clears `done`/`rdata`.
  - Re-initializes memory.
  - No partial write occurs.

## Structure
- Package `i2c_pkg`:
  - Master and slave state enums.
  - Quarter-phase enum.
  - Localparams `BIT`/`Q` derived from `SYS_FREQ`/`I2C_FREQ`.
- Sub-modules:
  - `i2c_master`, instantiated as `e1`, owning `sclk_ref`.
  - `i2c_mem_slave`, instantiated as `e2`.
- `i2c_mem_top` contains only the tri1 bus nets and wiring.

## Test plan
- Reset, then read addr 5 → `done` pulse, `rdata` = 0x05 (reset pattern).
- Write addr 0x12 = 0xA5, then read addr 0x12 → `rdata` = 0xA5. Each `done` arrives ≈ 20·`BIT` cycles after its request.
- Write addr 127 = 0xFF and addr 0 = 0x00, read both back → 0xFF, 0x00; no aliasing.
- Pulse `newd` again while busy → ignored: one `done` only, memory unchanged by the second request.
- Assert `rst` mid-write of addr 3 = 0x77, then read addr 3 → 0x03; bus idle high after reset.
- 20 random write/read pairs against a reference model:
  - All match.
  - SDA changes only while SCL is low, except at START/STOP.
  - `sclk_ref` period = `BIT`.
